sdram_cmd_sequencer: RTL and testbench
======================================

Name: sdram_cmd_sequencer

Overview:
- Initiator-side partner of the team's Delay counter block.
- Accepts single read/write requests from the parallel bus and walks the SDRAM command sequence PRECHARGE → ACTIVE → READ/WRITE burst → recovery.
- For each timing phase it pulses the matching Delay load strobe (Load_tPRE/Load_tCAS/Load_tBURST/Load_tWAIT), then waits until the Delay CountOut returns to zero.
- Optional page mode skips PRECHARGE and ACTIVE when the requested row is already open.

Parameters:
- ROW_W, 12, row address width
- COL_W, 8, column address width
- PAGE_MODE, 1, 1 = skip PRE/ACT on open-row hit; 0 = always run full sequence

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- Request  in  1  bus request, sampled only in IDLE
- WriteEn  in  1  1 = write, 0 = read; latched with Request
- Address  in  ROW_W+COL_W  {row, col}; latched with Request
- CountOut  in  3  remaining count from the Delay counter
- Load_tPRE  out  1  one-cycle load strobe to Delay
- Load_tCAS  out  1  one-cycle load strobe to Delay
- Load_tBURST  out  1  one-cycle load strobe to Delay
- Load_tWAIT  out  1  one-cycle load strobe to Delay
- Cmd  out  3  SDRAM command: NOP=000, PRE=001, ACT=010, RD=011, WR=100
- RowAddr  out  ROW_W  latched row
- ColAddr  out  COL_W  latched column
- DataPhase  out  1  high while burst data is valid
- Busy  out  1  high in any state except IDLE
- Ack  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, active-high):
  - state = IDLE; row-open flag cleared; RowAddr and ColAddr = 0.
  - All strobes, DataPhase, Busy and Ack = 0; Cmd = NOP.
  - Reset mid-sequence aborts immediately; no Ack is produced.
- Outputs are decoded from the state register only. There is no combinational path from any input to any output.
- States and transitions:
  - IDLE: if Request=1, latch WriteEn, RowAddr and ColAddr. If PAGE_MODE=1, the row-open flag is set, and the new row equals the open row → RW; otherwise → PRE. Request=0 → stay.
  - PRE: Cmd=PRE, Load_tPRE=1 → PRE_W.
  - PRE_W: wait until CountOut==0 → ACT.
  - ACT: Cmd=ACT, Load_tCAS=1; set row-open flag and record the open row → ACT_W.
  - ACT_W: wait until CountOut==0 → RW.
  - RW: Cmd=RD or WR per latched WriteEn; Load_tBURST=1 → BURST.
  - BURST: DataPhase = (CountOut != 0). When CountOut==0 → REC.
  - REC: Load_tWAIT=1 → REC_W.
  - REC_W: wait until CountOut==0 → DONE.
  - DONE: Ack=1 → IDLE.
- Exactly one load strobe is high in a given cycle, and only in PRE/ACT/RW/REC. Cmd is NOP in every state except PRE, ACT and RW.
- A wait state is always entered one cycle after its load, so CountOut already holds the freshly loaded value. A stale zero is never sampled.
- Request while Busy is ignored; there is no queuing. Request held high in DONE is not accepted until the sequencer is back in IDLE, giving a minimum of one IDLE cycle between transactions.
- A PAGE_MODE hit never clears the open row. PAGE_MODE=0 ignores the row-open flag.
- Latency with Delay loads PRE=4, CAS=6, BURST=7, WAIT=4, counting cycles after the Request sampling edge:
  - Full sequence: Ack in cycle 30; DataPhase high for cycles 16–22 (7 cycles).
  - Page hit: RW in cycle 1; DataPhase in cycles 2–8; Ack in cycle 16.

Test Plan:
- Reset, then read to Address={row 0x123, col 0x45} with Request pulsed one cycle → Cmd sequence PRE, ACT, RD with loads in cycles 1, 7, 15, 24; DataPhase 7 cycles; Ack single pulse in cycle 30; RowAddr=0x123, ColAddr=0x45.
- PAGE_MODE=1: second write to row 0x123, col 0x10 after the first completes → no PRE/ACT; Cmd=WR in cycle 1; Ack in cycle 16.
- PAGE_MODE=1: request to row 0x124 after row 0x123 is open → full sequence with PRE issued; Ack in cycle 30.
- Request held high continuously for 100 cycles → transactions back-to-back, each separated by one IDLE cycle; no request accepted while Busy=1.
- Assert reset during BURST (cycle 19) → all outputs 0/NOP immediately; no Ack; next request runs the full sequence (row flag cleared).
- PAGE_MODE=0, two requests to the same row → both run PRE and ACT; Ack at cycle 30 of each.

Source files
------------

// File: rtl/sdram_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// sdram_cmd_sequencer
//
// Initiator-side partner of the Delay counter. Takes single read/write
// requests from the parallel bus and walks the SDRAM command sequence
// PRECHARGE -> ACTIVE -> READ/WRITE burst -> recovery. For each timing phase
// it pulses one Delay load strobe, then waits for the Delay CountOut to
// return to zero. With PAGE_MODE=1 a request to the currently open row skips
// PRECHARGE and ACTIVE.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high reset
//   Request      bus request, sampled only in IDLE
//   WriteEn      1 = write, 0 = read; latched with Request
//   Address      {row, col}; latched with Request
//   CountOut     remaining count from the Delay counter
//   Load_tPRE    one-cycle Delay load strobe, precharge phase
//   Load_tCAS    one-cycle Delay load strobe, activate-to-CAS phase
//   Load_tBURST  one-cycle Delay load strobe, burst phase
//   Load_tWAIT   one-cycle Delay load strobe, recovery phase
//   Cmd          SDRAM command: NOP=000, PRE=001, ACT=010, RD=011, WR=100
//   RowAddr      latched row
//   ColAddr      latched column
//   DataPhase    high while burst data is valid
//   Busy         high in any state except IDLE
//   Ack          one-cycle completion pulse
//
// Every output is a flop updated together with the state register, so there
// is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module sdram_cmd_sequencer #(
  parameter int ROW_W     = 12,
  parameter int COL_W     = 8,
  parameter int PAGE_MODE = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   Request,
  input  logic                   WriteEn,
  input  logic [ROW_W+COL_W-1:0] Address,
  input  logic [2:0]             CountOut,
  output logic                   Load_tPRE,
  output logic                   Load_tCAS,
  output logic                   Load_tBURST,
  output logic                   Load_tWAIT,
  output logic [2:0]             Cmd,
  output logic [ROW_W-1:0]       RowAddr,
  output logic [COL_W-1:0]       ColAddr,
  output logic                   DataPhase,
  output logic                   Busy,
  output logic                   Ack
);

  localparam logic [2:0] CMD_NOP = 3'b000;
  localparam logic [2:0] CMD_PRE = 3'b001;
  localparam logic [2:0] CMD_ACT = 3'b010;
  localparam logic [2:0] CMD_RD  = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;

  typedef enum logic [3:0] {
    IDLE,
    PRE,
    PRE_W,
    ACT,
    ACT_W,
    RW,
    BURST,
    REC,
    REC_W,
    DONE
  } state_t;

  state_t           state;
  logic             writeLatched;
  logic             rowOpen;
  logic [ROW_W-1:0] openRow;

  // Open-row hit for the incoming request; only meaningful in IDLE.
  logic pageHit;
  assign pageHit = (PAGE_MODE != 0) && rowOpen &&
                   (Address[ROW_W+COL_W-1 -: ROW_W] == openRow);

  // Outputs are assigned for the state being entered, so they line up with
  // the state register in the same cycle.
  // NOTE: all state and output flops use non-blocking assignments so every
  // register samples pre-edge values and the block models real flip-flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      writeLatched <= 1'b0;
      rowOpen      <= 1'b0;
      openRow      <= '0;
      RowAddr      <= '0;
      ColAddr      <= '0;
      Load_tPRE    <= 1'b0;
      Load_tCAS    <= 1'b0;
      Load_tBURST  <= 1'b0;
      Load_tWAIT   <= 1'b0;
      Cmd          <= CMD_NOP;
      DataPhase    <= 1'b0;
      Busy         <= 1'b0;
      Ack          <= 1'b0;
    end else begin
      // Pulses and commands last a single cycle unless re-asserted below.
      Load_tPRE   <= 1'b0;
      Load_tCAS   <= 1'b0;
      Load_tBURST <= 1'b0;
      Load_tWAIT  <= 1'b0;
      Cmd         <= CMD_NOP;
      DataPhase   <= 1'b0;
      Ack         <= 1'b0;

      case (state)
        IDLE: begin
          if (Request) begin
            writeLatched <= WriteEn;
            RowAddr      <= Address[ROW_W+COL_W-1 -: ROW_W];
            ColAddr      <= Address[COL_W-1:0];
            Busy         <= 1'b1;
            if (pageHit) begin
              state       <= RW;
              Cmd         <= WriteEn ? CMD_WR : CMD_RD;
              Load_tBURST <= 1'b1;
            end else begin
              state     <= PRE;
              Cmd       <= CMD_PRE;
              Load_tPRE <= 1'b1;
            end
          end
        end

        // The Delay counter loads on the edge leaving PRE, so PRE_W already
        // sees the fresh count and never a stale zero.
        PRE: state <= PRE_W;

        PRE_W: begin
          if (CountOut == 3'd0) begin
            state     <= ACT;
            Cmd       <= CMD_ACT;
            Load_tCAS <= 1'b1;
          end
        end

        ACT: begin
          state   <= ACT_W;
          rowOpen <= 1'b1;
          openRow <= RowAddr;
        end

        ACT_W: begin
          if (CountOut == 3'd0) begin
            state       <= RW;
            Cmd         <= writeLatched ? CMD_WR : CMD_RD;
            Load_tBURST <= 1'b1;
          end
        end

        // The burst count is loaded on this edge and is non-zero in the
        // first BURST cycle, so data is valid from that cycle on.
        RW: begin
          state     <= BURST;
          DataPhase <= 1'b1;
        end

        // Registered form of DataPhase = (CountOut != 0): the Delay counter
        // decrements by one per cycle, so next cycle's count is non-zero
        // exactly when the present count is above one.
        BURST: begin
          if (CountOut == 3'd0) begin
            state      <= REC;
            Load_tWAIT <= 1'b1;
          end else begin
            DataPhase <= (CountOut > 3'd1);
          end
        end

        REC: state <= REC_W;

        REC_W: begin
          if (CountOut == 3'd0) begin
            state <= DONE;
            Ack   <= 1'b1;
          end
        end

        // Returning through IDLE guarantees one idle cycle between
        // transactions even when Request is held high.
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sdram_cmd_sequencer
//
// Directed bench for sdram_cmd_sequencer. Two instances share clock, reset,
// WriteEn and Address: dutPage (PAGE_MODE=1) and dutFull (PAGE_MODE=0). Each
// drives a small Delay counter model (PRE=4, CAS=6, BURST=7, WAIT=4).
// Expected per-cycle output vectors come from hand-derived schedules of the
// full and the page-hit transaction.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_cmd_sequencer;

  localparam int ROW_W = 12;
  localparam int COL_W = 8;

  localparam logic [2:0] NOP = 3'b000;
  localparam logic [2:0] PRE = 3'b001;
  localparam logic [2:0] ACT = 3'b010;
  localparam logic [2:0] RD  = 3'b011;
  localparam logic [2:0] WR  = 3'b100;

  // Cycle of a full transaction / page hit that is the trailing IDLE cycle.
  localparam int FULL_LEN = 31;
  localparam int PAGE_LEN = 17;

  logic                   clock;
  logic                   reset;
  logic                   WriteEn;
  logic [ROW_W+COL_W-1:0] Address;

  logic                   reqPage, reqFull;
  logic [2:0]             cntPage, cntFull;

  logic                   preP, casP, burstP, waitP, dpP, busyP, ackP;
  logic [2:0]             cmdP;
  logic [ROW_W-1:0]       rowP;
  logic [COL_W-1:0]       colP;

  logic                   preF, casF, burstF, waitF, dpF, busyF, ackF;
  logic [2:0]             cmdF;
  logic [ROW_W-1:0]       rowF;
  logic [COL_W-1:0]       colF;

  int compared   = 0;
  int mismatched = 0;

  sdram_cmd_sequencer #(.ROW_W(ROW_W), .COL_W(COL_W), .PAGE_MODE(1)) dutPage (
    .clock(clock), .reset(reset), .Request(reqPage), .WriteEn(WriteEn),
    .Address(Address), .CountOut(cntPage),
    .Load_tPRE(preP), .Load_tCAS(casP), .Load_tBURST(burstP), .Load_tWAIT(waitP),
    .Cmd(cmdP), .RowAddr(rowP), .ColAddr(colP),
    .DataPhase(dpP), .Busy(busyP), .Ack(ackP)
  );

  sdram_cmd_sequencer #(.ROW_W(ROW_W), .COL_W(COL_W), .PAGE_MODE(0)) dutFull (
    .clock(clock), .reset(reset), .Request(reqFull), .WriteEn(WriteEn),
    .Address(Address), .CountOut(cntFull),
    .Load_tPRE(preF), .Load_tCAS(casF), .Load_tBURST(burstF), .Load_tWAIT(waitF),
    .Cmd(cmdF), .RowAddr(rowF), .ColAddr(colF),
    .DataPhase(dpF), .Busy(busyF), .Ack(ackF)
  );

  // Delay counter models: load on strobe, otherwise count down to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)             cntPage <= 3'd0;
    else if (preP)         cntPage <= 3'd4;
    else if (casP)         cntPage <= 3'd6;
    else if (burstP)       cntPage <= 3'd7;
    else if (waitP)        cntPage <= 3'd4;
    else if (cntPage != 0) cntPage <= cntPage - 3'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)             cntFull <= 3'd0;
    else if (preF)         cntFull <= 3'd4;
    else if (casF)         cntFull <= 3'd6;
    else if (burstF)       cntFull <= 3'd7;
    else if (waitF)        cntFull <= 3'd4;
    else if (cntFull != 0) cntFull <= cntFull - 3'd1;
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output vector: {Cmd, tPRE, tCAS, tBURST, tWAIT, DataPhase, Busy, Ack}
  logic [9:0] vecPage, vecFull;
  assign vecPage = {cmdP, preP, casP, burstP, waitP, dpP, busyP, ackP};
  assign vecFull = {cmdF, preF, casF, burstF, waitF, dpF, busyF, ackF};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Expected vector in cycle k (1-based, counted from the Request sampling
  // edge). Full: loads 1/7/15/24, data 16-22, Ack 30, idle 31.
  // Page hit: burst load 1, data 2-8, wait load 10, Ack 16, idle 17.
  function automatic logic [9:0] expVec(input bit full, input bit wr,
                                        input int k);
    logic [2:0] rw;
    logic [9:0] v;
    rw = wr ? WR : RD;
    v  = '0;
    if (full) begin
      v[1] = (k >= 1 && k <= 30);
      if (k == 1)  begin v[9:7] = PRE; v[6] = 1'b1; end
      if (k == 7)  begin v[9:7] = ACT; v[5] = 1'b1; end
      if (k == 15) begin v[9:7] = rw;  v[4] = 1'b1; end
      if (k == 24) v[3] = 1'b1;
      v[2] = (k >= 16 && k <= 22);
      v[0] = (k == 30);
    end else begin
      v[1] = (k >= 1 && k <= 16);
      if (k == 1)  begin v[9:7] = rw; v[4] = 1'b1; end
      if (k == 10) v[3] = 1'b1;
      v[2] = (k >= 2 && k <= 8);
      v[0] = (k == 16);
    end
    return v;
  endfunction

  // Issues a request at the negedge (sampled on the following posedge) and
  // checks ncyc cycles. With hold=1 Request stays high and the schedule is
  // expected to repeat with its natural period.
  task automatic runTxn(input string name, input bit useFull, input bit wr,
                        input logic [ROW_W+COL_W-1:0] addr, input bit full,
                        input int ncyc, input bit hold);
    int period;
    int phase;
    period  = full ? FULL_LEN : PAGE_LEN;
    WriteEn = wr;
    Address = addr;
    if (useFull) reqFull = 1'b1; else reqPage = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clock);
      if (!hold) begin
        reqFull = 1'b0;
        reqPage = 1'b0;
      end
      phase = ((k - 1) % period) + 1;
      check($sformatf("%s c%0d", name, k),
            32'(useFull ? vecFull : vecPage), 32'(expVec(full, wr, phase)));
    end
  endtask

  task automatic waitIdlePage(input string name, input int budget);
    int n;
    n = 0;
    while (busyP && n < budget) begin
      @(negedge clock);
      n++;
    end
    check({name, " idle"}, 32'(busyP), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    reqPage = 1'b0;
    reqFull = 1'b0;
    WriteEn = 1'b0;
    Address = '0;
    repeat (2) @(negedge clock);
    check("reset vec", 32'(vecPage), 32'd0);
    check("reset row", 32'(rowP), 32'd0);
    check("reset col", 32'(colP), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Full read, then page-hit write, then miss to another row.
    runTxn("rd123", 1'b0, 1'b0, {12'h123, 8'h45}, 1'b1, FULL_LEN, 1'b0);
    check("rd123 row", 32'(rowP), 32'h123);
    check("rd123 col", 32'(colP), 32'h45);
    runTxn("wrHit", 1'b0, 1'b1, {12'h123, 8'h10}, 1'b0, PAGE_LEN, 1'b0);
    check("wrHit col", 32'(colP), 32'h10);
    runTxn("rd124", 1'b0, 1'b0, {12'h124, 8'h01}, 1'b1, FULL_LEN, 1'b0);
    check("rd124 row", 32'(rowP), 32'h124);

    // Request held for 100 cycles on the open row: back-to-back page hits,
    // one IDLE cycle apart.
    runTxn("held", 1'b0, 1'b1, {12'h124, 8'h22}, 1'b0, 100, 1'b1);
    reqPage = 1'b0;
    waitIdlePage("held", 40);

    // Reset in the middle of the burst of a miss to row 0x200.
    runTxn("abort", 1'b0, 1'b0, {12'h200, 8'h33}, 1'b1, 19, 1'b0);
    reset = 1'b1;
    #1;
    check("abort vec", 32'(vecPage), 32'd0);
    check("abort row", 32'(rowP), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (ackP || busyP) check($sformatf("abort quiet c%0d", k),
                               32'({busyP, ackP}), 32'd0);
    end
    check("abort quiet", 32'({busyP, ackP}), 32'd0);
    // Open-row flag was cleared, so the same row runs the full sequence.
    runTxn("rd200", 1'b0, 1'b0, {12'h200, 8'h34}, 1'b1, FULL_LEN, 1'b0);

    // PAGE_MODE=0: same row twice, both full sequences.
    runTxn("nopg1", 1'b1, 1'b0, {12'h055, 8'h0a}, 1'b1, FULL_LEN, 1'b0);
    runTxn("nopg2", 1'b1, 1'b1, {12'h055, 8'h0b}, 1'b1, FULL_LEN, 1'b0);
    check("nopg row", 32'(rowF), 32'h055);
    check("nopg col", 32'(colF), 32'h0b);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
